reg_cmd_parser: RTL

- Byte-stream command front end that sits directly upstream of the 8x16 register file.
- Accepts command bytes over a valid/ready stream and decodes write and read frames.
- Drives the register file write port with single-cycle write strobes, and its read port with read requests.
- Returns read data on a valid/ready response stream; malformed or stalled frames are dropped and counted.

---
 rtl/reg_cmd_parser_pkg.sv | 22 ++
 rtl/reg_cmd_timeout.sv | 28 ++
 rtl/reg_cmd_parser.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/reg_cmd_parser_pkg.sv
// Shared definitions for the register-file command parser: opcodes, FSM states
// and command-byte field positions.
package reg_cmd_parser_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Command byte layout: [7:6] opcode, [5:addr_w] reserved (zero), [addr_w-1:0] address.
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RSV_MSB = 5;

  typedef enum logic [2:0] {
    StIdle,
    StGetData,
    StWrite,
    StReadReq,
    StReadWait,
    StResp
  } state_e;

endpackage

// File: rtl/reg_cmd_timeout.sv
// Clearable saturating idle counter; 'reached' flags the increment that hits LIMIT.
module reg_cmd_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic reached
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CW'(LIMIT))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign reached = inc && !clr && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/reg_cmd_parser.sv
// Byte-stream command parser driving the write and read ports of a register file;
// malformed or stalled frames are dropped and counted in err_cnt.
module reg_cmd_parser
  import reg_cmd_parser_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [WIDTH-1:0]  wr_data_q, resp_q;
  logic [7:0]        err_q;

  logic              lat_wr_addr, lat_rd_addr, lat_data, cap_resp, err_inc;
  logic              tmo_inc, tmo_clr, tmo_reached;

  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rsv_ok, cmd_addr_ok, cmd_wr, cmd_rd;

  assign cmd_op      = in_data[OP_MSB:OP_LSB];
  assign cmd_addr    = in_data[ADDR_W-1:0];
  assign cmd_rsv_ok  = (in_data[RSV_MSB:0] >> ADDR_W) == '0;
  assign cmd_addr_ok = 32'(cmd_addr) < DEPTH;
  assign cmd_wr      = (cmd_op == OP_WRITE) && cmd_rsv_ok && cmd_addr_ok;
  assign cmd_rd      = (cmd_op == OP_READ) && cmd_rsv_ok && cmd_addr_ok;

  assign tmo_clr = (state_q != StGetData);

  reg_cmd_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .reached(tmo_reached)
  );

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    out_valid   = 1'b0;
    lat_wr_addr = 1'b0;
    lat_rd_addr = 1'b0;
    lat_data    = 1'b0;
    cap_resp    = 1'b0;
    err_inc     = 1'b0;
    tmo_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so no byte is taken mid-reset.
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          if (cmd_wr) begin
            lat_wr_addr = 1'b1;
            state_d     = StGetData;
          end else if (cmd_rd) begin
            lat_rd_addr = 1'b1;
            state_d     = StReadReq;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      StGetData: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          lat_data = 1'b1;
          state_d  = StWrite;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_reached) begin
            err_inc = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWrite: begin
        wr_en   = 1'b1;
        state_d = StIdle;
      end
      StReadReq: begin
        rd_en   = 1'b1;
        state_d = StReadWait;
      end
      StReadWait: begin
        cap_resp = 1'b1;
        state_d  = StResp;
      end
      StResp: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
      resp_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      if (lat_wr_addr) wr_addr_q <= cmd_addr;
      if (lat_rd_addr) rd_addr_q <= cmd_addr;
      if (lat_data)    wr_data_q <= in_data;
      if (cap_resp)    resp_q    <= rd_data;
      if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = rd_addr_q;
  assign out_data = resp_q;
  assign err_cnt  = err_q;
  assign busy     = (state_q != StIdle);

endmodule
